// File: rtl/seq_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Two's-complement overflow of a - b: operand signs differ and result sign differs from a.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic d_msb, input logic signed_mode);
    return signed_mode && (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_subtractor_if.sv
// Operand/result handshake bundle for seq_subtractor.
interface seq_subtractor_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, a, b, bin, signed_mode, out_ready,
    input  in_ready, out_valid, diff, bout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, bin, signed_mode, out_ready,
    output in_ready, out_valid, diff, bout, overflow, zero
  );
endinterface

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple-borrow subtractor: d = x - y - bin.
module digit_subtractor #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] d_o,
  output logic             bout_o
);

  logic borrow;

  always_comb begin
    borrow = bin_i;
    d_o    = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      d_o[i] = x_i[i] ^ y_i[i] ^ borrow;
      borrow = (~x_i[i] & y_i[i]) | (~(x_i[i] ^ y_i[i]) & borrow);
    end
    bout_o = borrow;
  end

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock from LSB to MSB.
module seq_subtractor #(
  parameter int unsigned W     = 8,
  parameter int unsigned DIGIT = 2
) (
  input logic              clk,
  input logic              rst,
  seq_subtractor_if.slave  io
);
  import seq_sub_pkg::*;

  localparam int unsigned NDIG = W / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (W < 2 || (W % DIGIT) != 0) begin : g_bad_param
    $error("seq_subtractor: W must be >= 2 and a multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              signed_q, signed_d;
  logic [W-1:0]      diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [DIGIT-1:0]  dig_x, dig_y, dig_d;
  logic              dig_bout;
  logic              accept;
  logic              last_digit;

  assign io.in_ready  = (state_q == StIdle) && !rst;
  assign io.out_valid = (state_q == StDone);
  assign io.diff      = diff_q;
  assign io.bout      = bout_q;
  assign io.overflow  = ovf_q;
  assign io.zero      = zero_q;

  assign accept     = io.in_valid && io.in_ready;
  assign last_digit = (cnt_q == CntW'(NDIG - 1));

  // Constant-select mux keeps the digit routing free of variable part-selects.
  always_comb begin
    dig_x = '0;
    dig_y = '0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (cnt_q == CntW'(k)) begin
        dig_x = a_q[k*DIGIT +: DIGIT];
        dig_y = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  digit_subtractor #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x_i    (dig_x),
    .y_i    (dig_y),
    .bin_i  (borrow_q),
    .d_o    (dig_d),
    .bout_o (dig_bout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d      = io.a;
          b_d      = io.b;
          signed_d = io.signed_mode;
          borrow_d = io.bin;
          cnt_d    = '0;
          diff_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        for (int k = 0; k < int'(NDIG); k++) begin
          if (cnt_q == CntW'(k)) begin
            diff_d[k*DIGIT +: DIGIT] = dig_d;
          end
        end
        borrow_d = dig_bout;
        cnt_d    = cnt_q + CntW'(1);
        if (last_digit) begin
          bout_d  = dig_bout;
          zero_d  = (diff_d == '0);
          ovf_d   = signed_ovf(a_q[W-1], b_q[W-1], diff_d[W-1], signed_q);
          state_d = StDone;
        end
      end
      StDone: begin
        if (io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_subtractor.sv
// Bench for seq_subtractor: directed table, random ops against an arithmetic model, corner sequences.
module tb_seq_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_subtractor_if #(.W(8)) if0 ();
  seq_subtractor_if #(.W(8)) if1 ();

  seq_subtractor #(.W(8), .DIGIT(2)) dut0 (.clk(clk), .rst(rst), .io(if0));
  seq_subtractor #(.W(8), .DIGIT(8)) dut1 (.clk(clk), .rst(rst), .io(if1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       sm;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    int         hold;
    bit         pulse;
  } vec_t;

  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic sm, output logic [7:0] d, output logic bo,
                       output logic ov, output logic z);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = ua - ub - int'(bin);
    sr = sa - sb - int'(bin);
    d  = 8'(r & 255);
    bo = (ua < ub + int'(bin));
    ov = sm && (sr < -128 || sr > 127);
    z  = (d == 8'h00);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic sm,
                    input logic [7:0] ed, input logic eb, input logic eo, input logic ez,
                    input int hold, input bit pulse);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", 32'(if0.in_ready), 1);
    if0.a           = a;
    if0.b           = b;
    if0.bin         = bin;
    if0.signed_mode = sm;
    if0.in_valid    = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; optionally keep in_valid asserted during RUN.
    if0.in_valid    = pulse;
    if0.a           = 8'($urandom);
    if0.b           = 8'($urandom);
    if0.bin         = 1'($urandom);
    if0.signed_mode = 1'($urandom);
    lat = 0;
    while (!if0.out_valid && lat < 20) begin
      chk("in_ready_busy", 32'(if0.in_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    if0.in_valid = 1'b0;
    chk("latency", 32'(lat), 4);
    chk("diff", 32'(if0.diff), 32'(ed));
    chk("bout", 32'(if0.bout), 32'(eb));
    chk("overflow", 32'(if0.overflow), 32'(eo));
    chk("zero", 32'(if0.zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(if0.out_valid), 1);
      chk("hold_diff", 32'(if0.diff), 32'(ed));
      chk("hold_ready", 32'(if0.in_ready), 0);
    end
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.out_ready = 1'b0;
    chk("post_valid", 32'(if0.out_valid), 0);
    chk("post_ready", 32'(if0.in_ready), 1);
    chk("post_diff", 32'(if0.diff), 32'(ed));
    chk("post_bout", 32'(if0.bout), 32'(eb));
  endtask

  initial begin
    logic [7:0] ra, rb, ed;
    logic       rbin, rsm, eb, eo, ez;
    int         lat;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 5, 1'b1};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[2] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    tbl[5] = '{8'h7F, 8'h7E, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[6] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1, 1'b0};

    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.bin = 1'b0;
    if0.signed_mode = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
    if1.signed_mode = 1'b0; if1.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(if0.in_ready), 0);
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_diff", 32'(if0.diff), 0);
    chk("rst_flags", 32'({if0.bout, if0.overflow, if0.zero}), 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(if0.in_ready), 1);
    chk("rst_release_ready1", 32'(if1.in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].sm, tbl[i].diff, tbl[i].bout, tbl[i].ovf,
         tbl[i].zero, tbl[i].hold, tbl[i].pulse);
    end

    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom);
      rb   = (i % 7 == 0) ? ra : 8'($urandom);
      rbin = 1'($urandom);
      rsm  = 1'($urandom);
      model(ra, rb, rbin, rsm, ed, eb, eo, ez);
      op(ra, rb, rbin, rsm, ed, eb, eo, ez, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset on the second RUN cycle, after a result that left flags set.
    op(8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    if0.a = 8'h33; if0.b = 8'h11; if0.bin = 1'b0; if0.in_valid = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(if0.in_ready), 0);
    @(posedge clk); #1;
    chk("midrst_valid", 32'(if0.out_valid), 0);
    chk("midrst_diff", 32'(if0.diff), 0);
    chk("midrst_flags", 32'({if0.bout, if0.overflow, if0.zero}), 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(if0.in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_result", 32'(if0.out_valid), 0);
    end

    // DIGIT = W: one RUN cycle.
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      if1.a   = (j == 0) ? 8'h05 : 8'h7F;
      if1.b   = (j == 0) ? 8'h03 : 8'h7F;
      if1.bin = (j == 0) ? 1'b0 : 1'b1;
      if1.in_valid = 1'b1;
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      lat = 0;
      while (!if1.out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("d8_latency", 32'(lat), 1);
      chk("d8_diff", 32'(if1.diff), (j == 0) ? 32'h02 : 32'hFF);
      chk("d8_bout", 32'(if1.bout), (j == 0) ? 32'd0 : 32'd1);
      chk("d8_zero", 32'(if1.zero), 0);
      if1.out_ready = 1'b1;
      @(posedge clk); #1;
      if1.out_ready = 1'b0;
      chk("d8_post_valid", 32'(if1.out_valid), 0);
      chk("d8_post_ready", 32'(if1.in_ready), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_subtractor.md
Name: seq_subtractor

Overview:
Parametrised multi-cycle subtractor that computes diff = a - b - bin over W-bit operands, processing DIGIT bits per clock from LSB to MSB.
- The borrow is held in a register between digits.
- Operands enter through a valid/ready input handshake; results leave through a valid/ready output handshake.
- Reports borrow-out, signed overflow and a zero flag.
- Serves as the area-lean arithmetic unit for datapaths where the full-width ripple subtractor is too large.

Parameters:
W, 8, operand/result width in bits (W >= 2)
DIGIT, 2, bits processed per cycle; W % DIGIT == 0 is required (elaboration error otherwise)
NDIG, W/DIGIT, derived digit count (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  W  minuend
b  input  W  subtrahend
bin  input  1  borrow-in
signed_mode  input  1  1 = two's-complement overflow rules, 0 = unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  W  a - b - bin mod 2^W
bout  output  1  final borrow-out (unsigned a < b + bin)
overflow  output  1  signed overflow; 0 when signed_mode = 0
zero  output  1  diff == 0

Behaviour:
- Interface timing: single clock, synchronous active-high reset on rst; all state changes happen on rising clk.
- Reset values: state = IDLE; diff = 0, bout = 0, overflow = 0, zero = 0, out_valid = 0; internal digit counter and borrow register = 0.
- in_ready = (state == IDLE) && !rst, combinational.
- Reset mid-operation: an in-flight operation is abandoned and no result is emitted.

State machine:
- IDLE: when in_valid && in_ready, capture a, b, bin and signed_mode into working registers.
  - Set borrow register = bin, counter = 0, clear diff.
  - Go to RUN.
- RUN: each cycle, digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) is subtracted with the borrow register.
  - Write the digit result into diff[k*DIGIT +: DIGIT] and update the borrow register.
  - counter++.
  - On the cycle digit NDIG-1 completes: set bout = final borrow, zero = (full diff == 0), and overflow = signed_mode && (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]). Go to DONE.
- DONE: out_valid = 1. diff and flags are held stable until out_ready is sampled high.
  - On out_valid && out_ready, go to IDLE and clear out_valid.
  - diff and flags retain their values after the handoff.

Latency and throughput:
- out_valid rises NDIG cycles after the accept edge.
- No back-to-back accept: the earliest next accept is the cycle after the output handshake.
- Minimum initiation interval is NDIG + 2 cycles.

Boundary conditions:
- in_valid while in RUN or DONE is ignored; operands are not sampled and are not lost-accounted.
- Input changes after the accept edge have no effect (operands are latched).
- DIGIT = W gives single-cycle RUN (NDIG = 1).
- bin = 1 with a == b yields diff = all-ones, bout = 1.
- Wrap-around is modulo 2^W; there is no saturation.

Decomposition:
- Shared package seq_sub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - the function computing signed overflow from (a_msb, b_msb, d_msb, signed_mode).
- One sub-module, digit_subtractor #(DIGIT): purely combinational DIGIT-bit ripple (x, y, bin) -> (d, bout), built from per-bit diff = x^y^bin and bout = (~x&y) | (~(x^y)&bin).
- seq_subtractor instantiates it once and multiplexes the current digit into it.

Test Plan:
All scenarios use W=8, DIGIT=2 unless noted.
- Basic: a=0x05, b=0x03, bin=0, unsigned -> after 4 cycles out_valid: diff=0x02, bout=0, zero=0, overflow=0.
- Underflow wrap: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; with signed_mode=1, overflow=0.
- Signed overflow: a=0x80, b=0x01, signed_mode=1 -> diff=0x7F, bout=0, overflow=1. Same with signed_mode=0 -> overflow=0.
- Borrow-in and zero: a=0x7F, b=0x7E, bin=1 -> diff=0x00, zero=1, bout=0. Then a=b=0x7F, bin=1 -> diff=0xFF, bout=1, zero=0.
- Backpressure and ignore: hold out_ready=0 for 5 cycles in DONE -> out_valid and diff stay stable. Pulse in_valid during RUN -> no second accept; in_ready stays 0 until the cycle after the output handshake.
- Reset mid-run: assert rst on the 2nd RUN cycle -> next cycle state IDLE, out_valid=0, all outputs 0, in_ready=1 after rst deasserts. Also repeat scenario 1 with DIGIT=8 -> out_valid 1 cycle after accept.
